// File: rtl/sram_axi_bridge_mp_if.sv
// AXI3 master-side bus of the multi-port SRAM-to-AXI bridge.
// The bridge drives through the master modport; a slave model or fabric uses the slave modport.
interface sram_axi_bridge_mp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata_axi;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata_axi;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata_axi, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata_axi, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata_axi, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata_axi, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge_mp.sv
// NPORT SRAM-like ports sharing one AXI3 master; independent round-robin read and write
// arbiters, one outstanding transaction per port, responses routed back by RID/BID.
module sram_axi_bridge_mp #(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT-1:0]        wr,
  input  logic [2*NPORT-1:0]      size,
  input  logic [ADDR_W*NPORT-1:0] addr,
  input  logic [DATA_W*NPORT-1:0] wdata,
  output logic [NPORT-1:0]        addr_ok,
  output logic [NPORT-1:0]        data_ok,
  output logic [DATA_W-1:0]       rdata,
  output logic                    err,
  sram_axi_bridge_mp_if.master    axi
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int IDX_W  = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {P_IDLE, P_RD_PEND, P_WR_PEND} port_state_e;

  port_state_e         port_q [NPORT];
  logic [IDX_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic                rready_q, bready_q, err_q;

  logic                arvalid_q;
  logic [ID_W-1:0]     arid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [2:0]          arsize_q;

  logic                awvalid_q, wvalid_q;
  logic [ID_W-1:0]     awid_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [2:0]          awsize_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic [NPORT-1:0]    cand_rd, cand_wr, r_match, b_match;
  logic                rd_vld, wr_vld, r_fire, b_fire, err_set;
  logic [IDX_W-1:0]    rd_idx, wr_idx;
  logic [ADDR_W-1:0]   wr_addr;
  logic [1:0]          wr_size;

  // Byte-lane mask for a naturally aligned access of 2**sz bytes.
  function automatic logic [STRB_W-1:0] strb_of(input logic [1:0] sz,
                                                input logic [LANE_W-1:0] lane);
    logic [STRB_W-1:0] base;
    base = '0;
    for (int b = 0; b < STRB_W; b++) begin
      if (b < (1 << sz)) base[b] = 1'b1;
    end
    return base << lane;
  endfunction

  // NOTE: every variable written here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    int p;
    cand_rd = '0;
    cand_wr = '0;
    r_match = '0;
    b_match = '0;
    r_fire  = axi.rvalid & rready_q;
    b_fire  = axi.bvalid & bready_q;
    for (int i = 0; i < NPORT; i++) begin
      cand_rd[i] = req[i] & ~wr[i] & (port_q[i] == P_IDLE);
      cand_wr[i] = req[i] &  wr[i] & (port_q[i] == P_IDLE);
      r_match[i] = r_fire & (axi.rid == ID_W'(i)) & (port_q[i] == P_RD_PEND);
      b_match[i] = b_fire & (axi.bid == ID_W'(i)) & (port_q[i] == P_WR_PEND);
    end

    // Scan downward so the candidate closest to the pointer is the last one written.
    rd_vld = 1'b0;
    rd_idx = '0;
    wr_vld = 1'b0;
    wr_idx = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      p = (int'(rd_ptr_q) + k) % NPORT;
      if (cand_rd[p]) begin
        rd_vld = 1'b1;
        rd_idx = IDX_W'(p);
      end
      p = (int'(wr_ptr_q) + k) % NPORT;
      if (cand_wr[p]) begin
        wr_vld = 1'b1;
        wr_idx = IDX_W'(p);
      end
    end
    rd_vld = rd_vld & (~arvalid_q | axi.arready);
    wr_vld = wr_vld & ~awvalid_q & ~wvalid_q;

    addr_ok = '0;
    if (rd_vld) addr_ok[rd_idx] = 1'b1;
    if (wr_vld) addr_ok[wr_idx] = 1'b1;

    data_ok = r_match | b_match;
    rdata   = (|r_match) ? axi.rdata_axi : '0;
    err_set = (r_fire & ((axi.rresp != 2'b00) | ~(|r_match))) |
              (b_fire & ((axi.bresp != 2'b00) | ~(|b_match)));

    wr_addr = addr[int'(wr_idx)*ADDR_W +: ADDR_W];
    wr_size = size[int'(wr_idx)*2 +: 2];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the per-port state array is small control state, so it is reset like any
      // other register; in-flight transactions are dropped on reset.
      for (int i = 0; i < NPORT; i++) port_q[i] <= P_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      rready_q <= 1'b1;
      bready_q <= 1'b1;
      if (err_set) err_q <= 1'b1;

      for (int i = 0; i < NPORT; i++) begin
        if (addr_ok[i])      port_q[i] <= wr[i] ? P_WR_PEND : P_RD_PEND;
        else if (data_ok[i]) port_q[i] <= P_IDLE;
      end

      if (rd_vld) begin
        arvalid_q <= 1'b1;
        arid_q    <= ID_W'(rd_idx);
        araddr_q  <= addr[int'(rd_idx)*ADDR_W +: ADDR_W];
        arsize_q  <= {1'b0, size[int'(rd_idx)*2 +: 2]};
        rd_ptr_q  <= (int'(rd_idx) == NPORT - 1) ? '0 : rd_idx + 1'b1;
      end else if (axi.arready) begin
        arvalid_q <= 1'b0;
      end

      // AW and W retire independently; a new write waits until both have gone.
      if (wr_vld) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awid_q    <= ID_W'(wr_idx);
        awaddr_q  <= wr_addr;
        awsize_q  <= {1'b0, wr_size};
        wdata_q   <= wdata[int'(wr_idx)*DATA_W +: DATA_W];
        wstrb_q   <= strb_of(wr_size, wr_addr[LANE_W-1:0]);
        wr_ptr_q  <= (int'(wr_idx) == NPORT - 1) ? '0 : wr_idx + 1'b1;
      end else begin
        if (axi.awready) awvalid_q <= 1'b0;
        if (axi.wready)  wvalid_q  <= 1'b0;
      end
    end
  end

  assign err = err_q;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = awid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;

  assign axi.wid       = awid_q;
  assign axi.wdata_axi = wdata_q;
  assign axi.wstrb     = wstrb_q;
  assign axi.wlast     = wvalid_q;
  assign axi.wvalid    = wvalid_q;
  assign axi.bready    = bready_q;

  // Single-beat bursts only, so RLAST carries no extra information.
  logic unused_rlast;
  assign unused_rlast = axi.rlast;

endmodule

// File: tb/tb_sram_axi_bridge_mp.sv
// Directed bench for sram_axi_bridge_mp (NPORT=2, 32-bit data): reads, writes, arbitration,
// response routing, error flag and asynchronous reset, against hand-computed values.
module tb_sram_axi_bridge_mp;

  logic        clk;
  logic        resetn;
  logic [1:0]  req, wr;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic [1:0]  addr_ok, data_ok;
  logic [31:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  sram_axi_bridge_mp_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  sram_axi_bridge_mp #(.NPORT(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata),
    .err     (err),
    .axi     (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata_axi = '0;
    axi.rresp = '0; axi.rlast = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    #12;
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid",  axi.wvalid,  1'b0);
    check("rst_rready",  axi.rready,  1'b0);
    check("rst_bready",  axi.bready,  1'b0);
    check("rst_err",     err,         1'b0);
    check("rst_data_ok", data_ok,     2'b00);

    // Single read on port 0 with a zero-wait slave.
    do_reset();
    check("post_rst_rready", axi.rready, 1'b1);
    check("post_rst_bready", axi.bready, 1'b1);
    req = 2'b01; wr = 2'b00; size[1:0] = 2'd2; addr[31:0] = 32'h0000_1000;
    axi.arready = 1'b1;
    #1 check("t1_addr_ok", addr_ok, 2'b01);
    tick();
    req = 2'b00;
    #1;
    check("t1_arvalid", axi.arvalid, 1'b1);
    check("t1_arid",    axi.arid,    4'd0);
    check("t1_araddr",  axi.araddr,  32'h0000_1000);
    check("t1_arsize",  axi.arsize,  3'd2);
    check("t1_arlen",   axi.arlen,   8'd0);
    check("t1_arburst", axi.arburst, 2'b01);
    tick();
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata_axi = 32'hDEAD_BEEF; axi.rlast = 1'b1;
    #1;
    check("t1_data_ok", data_ok,     2'b01);
    check("t1_rdata",   rdata,       32'hDEAD_BEEF);
    check("t1_ar_done", axi.arvalid, 1'b0);
    tick();
    axi.rvalid = 1'b0;
    #1;
    check("t1_data_ok_off", data_ok, 2'b00);
    check("t1_err",         err,     1'b0);

    // Two reading ports: alternating grants and out-of-order responses.
    do_reset();
    req = 2'b11; wr = 2'b00; size = 4'b1010;
    addr = {32'h0000_3000, 32'h0000_2000};
    axi.arready = 1'b1;
    #1 check("t2_gnt0", addr_ok, 2'b01);
    tick();
    #1;
    check("t2_gnt1",     addr_ok,    2'b10);
    check("t2_arid0",    axi.arid,   4'd0);
    check("t2_araddr0",  axi.araddr, 32'h0000_2000);
    tick();
    req = 2'b00;
    axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata_axi = 32'h1111_1111; axi.rlast = 1'b1;
    #1;
    check("t2_arid1",    axi.arid,   4'd1);
    check("t2_araddr1",  axi.araddr, 32'h0000_3000);
    check("t2_dok_p1",   data_ok,    2'b10);
    check("t2_rdata_p1", rdata,      32'h1111_1111);
    tick();
    axi.rid = 4'd0; axi.rdata_axi = 32'h2222_2222;
    #1;
    check("t2_dok_p0",   data_ok,     2'b01);
    check("t2_rdata_p0", rdata,       32'h2222_2222);
    check("t2_ar_idle",  axi.arvalid, 1'b0);
    tick();
    axi.rvalid = 1'b0;
    req = 2'b11;
    #1 check("t2_gnt0_again", addr_ok, 2'b01);
    tick();
    #1;
    check("t2_gnt1_again", addr_ok,  2'b10);
    check("t2_arid0_again", axi.arid, 4'd0);
    tick();
    req = 2'b00;
    #1 check("t2_arid1_again", axi.arid, 4'd1);

    // Byte write on port 1 with a slow AW channel; port 0 write must wait.
    do_reset();
    req = 2'b10; wr = 2'b10; size[3:2] = 2'd0;
    addr[63:32] = 32'h0000_0103; wdata[63:32] = 32'hAA00_0000;
    axi.awready = 1'b0; axi.wready = 1'b1;
    #1 check("t3_gnt_p1", addr_ok, 2'b10);
    tick();
    req = 2'b01; wr = 2'b01; size[1:0] = 2'd2;
    addr[31:0] = 32'h0000_0040; wdata[31:0] = 32'h1234_5678;
    #1;
    check("t3_awvalid", axi.awvalid,   1'b1);
    check("t3_wvalid",  axi.wvalid,    1'b1);
    check("t3_awid",    axi.awid,      4'd1);
    check("t3_wid",     axi.wid,       4'd1);
    check("t3_awaddr",  axi.awaddr,    32'h0000_0103);
    check("t3_awsize",  axi.awsize,    3'd0);
    check("t3_wstrb",   axi.wstrb,     4'b1000);
    check("t3_wdata",   axi.wdata_axi, 32'hAA00_0000);
    check("t3_wlast",   axi.wlast,     1'b1);
    check("t3_blocked_c1", addr_ok,    2'b00);
    tick();
    #1;
    check("t3_w_done",     axi.wvalid,  1'b0);
    check("t3_aw_held",    axi.awvalid, 1'b1);
    check("t3_blocked_c2", addr_ok,     2'b00);
    tick();
    #1 check("t3_blocked_c3", addr_ok, 2'b00);
    tick();
    axi.awready = 1'b1;
    #1 check("t3_blocked_c4", addr_ok, 2'b00);
    tick();
    axi.bvalid = 1'b1; axi.bid = 4'd1; axi.bresp = 2'b00;
    #1;
    check("t3_aw_done",  axi.awvalid, 1'b0);
    check("t3_gnt_p0",   addr_ok,     2'b01);
    check("t3_b_dok_p1", data_ok,     2'b10);
    tick();
    axi.bvalid = 1'b0;
    req = 2'b00;
    #1;
    check("t3_awid_p0",  axi.awid,      4'd0);
    check("t3_wstrb_p0", axi.wstrb,     4'b1111);
    check("t3_wdata_p0", axi.wdata_axi, 32'h1234_5678);
    check("t3_err",      err,           1'b0);

    // Read on port 0 and write on port 1 granted in the same cycle.
    do_reset();
    req = 2'b11; wr = 2'b10; size = 4'b1010;
    addr = {32'h0000_0600, 32'h0000_0500}; wdata = {32'hCAFE_F00D, 32'h0};
    #1 check("t4_both_gnt", addr_ok, 2'b11);
    tick();
    req = 2'b00;
    #1;
    check("t4_arvalid", axi.arvalid, 1'b1);
    check("t4_awvalid", axi.awvalid, 1'b1);
    check("t4_wvalid",  axi.wvalid,  1'b1);
    check("t4_arid",    axi.arid,    4'd0);
    check("t4_awid",    axi.awid,    4'd1);
    tick();
    #1;
    check("t4_ar_hold",      axi.arvalid, 1'b1);
    check("t4_araddr_hold",  axi.araddr,  32'h0000_0500);

    // Error response and an unmatched R beat.
    do_reset();
    req = 2'b01; wr = 2'b00; size[1:0] = 2'd2; addr[31:0] = 32'h0000_0700;
    axi.arready = 1'b1;
    #1 check("t5_gnt", addr_ok, 2'b01);
    tick();
    req = 2'b00;
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rresp = 2'b10;
    axi.rdata_axi = 32'h5555_AAAA; axi.rlast = 1'b1;
    #1;
    check("t5_slverr_dok",   data_ok, 2'b01);
    check("t5_slverr_rdata", rdata,   32'h5555_AAAA);
    check("t5_err_not_yet",  err,     1'b0);
    tick();
    axi.rid = 4'd5; axi.rresp = 2'b00; axi.rdata_axi = 32'h0BAD_0BAD;
    #1;
    check("t5_err_set",   err,     1'b1);
    check("t5_stray_dok", data_ok, 2'b00);
    tick();
    axi.rvalid = 1'b0;
    #1 check("t5_err_sticky", err, 1'b1);

    // Asynchronous reset mid-transaction; read pointer sits at port 1 beforehand.
    req = 2'b01; wr = 2'b00; addr[31:0] = 32'h0000_0800;
    axi.arready = 1'b0;
    #1 check("t6_gnt", addr_ok, 2'b01);
    tick();
    req = 2'b00;
    #1;
    check("t6_arvalid_pre", axi.arvalid, 1'b1);
    check("t6_err_pre",     err,         1'b1);
    resetn = 1'b0;
    #1;
    check("t6_arvalid_rst", axi.arvalid, 1'b0);
    check("t6_rready_rst",  axi.rready,  1'b0);
    check("t6_bready_rst",  axi.bready,  1'b0);
    check("t6_err_rst",     err,         1'b0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    req = 2'b11; wr = 2'b00;
    #1;
    check("t6_first_gnt_p0", addr_ok,    2'b01);
    check("t6_rready_on",    axi.rready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
